serial_frame_sync_ctrl: RTL and testbench
=========================================

// Module: serial_frame_sync_ctrl
// PURPOSE
// Character-alignment controller for the serial-to-parallel receive path. Hunts the 1-bit S_IN
// stream for a COMMA character, verifies alignment over LOCK_COUNT consecutive commas, then emits
// aligned 8-bit characters with a one-cycle valid. Drops lock when commas stop arriving.
// Sits between the serial pin sampler and the byte-level consumer.
// PARAMETERS
// COMMA       8'hB4  alignment character, MSB received first (legal: any value except 8'h00)
// LOCK_COUNT  3      consecutive aligned commas required for lock (legal 2..15)
// MAX_GAP     4      non-comma characters in a row while locked that cause loss of lock (legal 1..15)
// PORTS
// CLK       in   1  clock, all logic on posedge
// RESET     in   1  synchronous, active-low reset
// S_IN      in   1  serial data bit, sampled only when S_VALID=1
// S_VALID   in   1  bit strobe; one bit per cycle with S_VALID=1
// P_OUT     out  8  aligned character, registered
// P_VALID   out  1  one-cycle pulse: P_OUT holds a new character
// P_COMMA   out  1  qualifies P_VALID: the character is COMMA
// LOCKED    out  1  level: alignment acquired
// SYNC_ERR  out  1  one-cycle pulse on loss of lock
// BEHAVIOUR
// - Reset (RESET=0 at posedge): state=HUNT, sr=0, fill=0, bit_cnt=0, comma_cnt=0, gap=0; P_OUT=0,
//   P_VALID=0, P_COMMA=0, LOCKED=0, SYNC_ERR=0. Reset overrides everything, including mid-character.
// - S_VALID=0: all state, counters and P_OUT hold; P_VALID/SYNC_ERR are 0 (pulses only).
// - On S_VALID=1: sr <= {sr[6:0],S_IN}; win = {sr[6:0],S_IN} (post-shift value used for compares).
//   fill counts bits received since reset/HUNT entry, saturates at 8; matches ignored while fill<7 pre-shift.
// - Boundary = S_VALID=1 and bit_cnt==7; bit_cnt increments mod 8 on every S_VALID in VERIFY/LOCKED.
// - HUNT: every S_VALID, if fill full and win==COMMA -> VERIFY, comma_cnt=1, bit_cnt=0. Else stay.
// - VERIFY: at boundary: win==COMMA -> comma_cnt+1; if that equals LOCK_COUNT -> LOCKED, gap=0,
//   LOCKED=1 next cycle. win!=COMMA -> HUNT, comma_cnt=0, fill=0. No P_VALID in VERIFY.
// - LOCKED: at boundary P_OUT<=win, P_COMMA<=(win==COMMA), P_VALID=1 next cycle (latency 1 cycle
//   after the strobe carrying the char's LSB). win==COMMA -> gap=0; else gap+1.
//   If gap+1==MAX_GAP: that char is NOT emitted (P_VALID=0), SYNC_ERR=1 one cycle, LOCKED=0,
//   state HUNT, fill=0, comma_cnt=0. The lock-completing comma itself is not emitted.
// - Registered outputs only; LOCKED high exactly while state==LOCKED (one cycle after transition).
// - Unreachable state encodings return to HUNT next cycle with outputs at reset values.
// TESTING
// 1 Reset: RESET=0 two cycles with S_IN toggling, S_VALID=1 -> all outputs 0, state HUNT.
// 2 Acquire: 3 junk bits 101, then B4,B4,B4,5A (S_VALID=1) -> LOCKED=1 cycle after 3rd comma LSB;
//   single P_VALID with P_OUT=5A, P_COMMA=0; no P_VALID for the commas.
// 3 Verify fail: B4,B4,00 -> LOCKED stays 0, back to HUNT; then B4x3 -> lock acquired normally.
// 4 Loss: locked, send 11,22,33,44 -> P_VALID for 11,22,33; on 44 no P_VALID, SYNC_ERR one cycle,
//   LOCKED=0; B4 inserted after 33 instead resets gap, lock kept, B4 emitted with P_COMMA=1.
// 5 Strobe gaps: locked, S_VALID 1-of-3 cycles sending A5 -> P_OUT=A5 once, outputs hold between bits.
// 6 Reset mid-char: LOCKED, RESET=0 after 4 bits of char -> all cleared; next B4 alone does not lock.

Source files
------------

// File: rtl/serial_frame_sync_ctrl.sv
// ============================================================================
// serial_frame_sync_ctrl
//
// Character-alignment controller for the serial-to-parallel receive path.
// Hunts the serial bit stream for the COMMA character, confirms alignment over
// LOCK_COUNT consecutive aligned commas, then emits every aligned 8-bit
// character with a one-cycle valid pulse. Lock is dropped, with a one-cycle
// SYNC_ERR pulse, once MAX_GAP non-comma characters arrive in a row.
//
// Parameters
//   COMMA       alignment character, MSB received first (must be non-zero)
//   LOCK_COUNT  consecutive aligned commas needed for lock (2..15)
//   MAX_GAP     consecutive non-commas while locked that drop lock (1..15)
//
// Ports
//   CLK       in   1  clock, all logic on posedge
//   RESET     in   1  synchronous, active-low reset
//   S_IN      in   1  serial data bit, sampled only when S_VALID=1
//   S_VALID   in   1  bit strobe, one bit per cycle with S_VALID=1
//   P_OUT     out  8  aligned character (registered, holds between updates)
//   P_VALID   out  1  one-cycle pulse: P_OUT holds a new character
//   P_COMMA   out  1  qualifies P_VALID: the character is COMMA
//   LOCKED    out  1  level: alignment acquired
//   SYNC_ERR  out  1  one-cycle pulse on loss of lock
// ============================================================================
module serial_frame_sync_ctrl #(
    parameter logic [7:0] COMMA      = 8'hB4,
    parameter int         LOCK_COUNT = 3,
    parameter int         MAX_GAP    = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       S_IN,
    input  logic       S_VALID,
    output logic [7:0] P_OUT,
    output logic       P_VALID,
    output logic       P_COMMA,
    output logic       LOCKED,
    output logic       SYNC_ERR
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] GAP_N  = 4'(MAX_GAP);

    state_t     r_state;
    logic [6:0] r_sr;          // only the 7 newest bits are ever needed for the window
    logic [3:0] r_fill;        // bits seen since reset / HUNT entry, saturates at 8
    logic [2:0] r_bit_cnt;     // position inside the current aligned character
    logic [3:0] r_comma_cnt;
    logic [3:0] r_gap;
    logic [7:0] r_p_out;
    logic       r_p_valid;
    logic       r_p_comma;
    logic       r_locked;
    logic       r_sync_err;

    // Window including the bit arriving this cycle; all compares use it.
    wire [7:0] w_win        = {r_sr, S_IN};
    wire       w_is_comma   = (w_win == COMMA);
    wire       w_fill_full  = (r_fill >= 4'd7);
    wire       w_boundary   = (r_bit_cnt == 3'd7);
    wire [3:0] w_comma_inc  = r_comma_cnt + 4'd1;
    wire [3:0] w_gap_next   = w_is_comma ? 4'd0 : (r_gap + 4'd1);
    wire       w_bad_state  = (r_state != ST_HUNT) && (r_state != ST_VERIFY) &&
                              (r_state != ST_LOCKED);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in this block override earlier ones.
    always_ff @(posedge CLK) begin
        if (!RESET || w_bad_state) begin
            // An illegal encoding recovers exactly like a reset.
            r_state     <= ST_HUNT;
            r_sr        <= 7'd0;
            r_fill      <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_gap       <= 4'd0;
            r_p_out     <= 8'd0;
            r_p_valid   <= 1'b0;
            r_p_comma   <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_p_valid  <= 1'b0;
            r_sync_err <= 1'b0;
            if (S_VALID) begin
                r_sr <= w_win[6:0];
                if (r_fill != 4'd8)
                    r_fill <= r_fill + 4'd1;

                case (r_state)
                    ST_HUNT: begin
                        if (w_fill_full && w_is_comma) begin
                            r_state     <= ST_VERIFY;
                            r_comma_cnt <= 4'd1;
                            r_bit_cnt   <= 3'd0;
                        end
                    end

                    ST_VERIFY: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_boundary) begin
                            if (w_is_comma) begin
                                r_comma_cnt <= w_comma_inc;
                                if (w_comma_inc == LOCK_N) begin
                                    // The lock-completing comma is not emitted.
                                    r_state  <= ST_LOCKED;
                                    r_gap    <= 4'd0;
                                    r_locked <= 1'b1;
                                end
                            end else begin
                                r_state     <= ST_HUNT;
                                r_comma_cnt <= 4'd0;
                                r_fill      <= 4'd0;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_boundary) begin
                            if (w_gap_next == GAP_N) begin
                                // Character that exhausts the gap budget is dropped.
                                r_state     <= ST_HUNT;
                                r_locked    <= 1'b0;
                                r_sync_err  <= 1'b1;
                                r_fill      <= 4'd0;
                                r_comma_cnt <= 4'd0;
                                r_gap       <= 4'd0;
                            end else begin
                                r_gap     <= w_gap_next;
                                r_p_out   <= w_win;
                                r_p_comma <= w_is_comma;
                                r_p_valid <= 1'b1;
                            end
                        end
                    end

                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign P_OUT    = r_p_out;
    assign P_VALID  = r_p_valid;
    assign P_COMMA  = r_p_comma;
    assign LOCKED   = r_locked;
    assign SYNC_ERR = r_sync_err;

endmodule

// File: tb/tb_serial_frame_sync_ctrl.sv
// ============================================================================
// tb_serial_frame_sync_ctrl
//
// Directed bench for serial_frame_sync_ctrl with default parameters
// (COMMA=B4, LOCK_COUNT=3, MAX_GAP=4). Inputs change on the falling edge,
// outputs are observed on the following falling edge, so each bit step shows
// the result of the rising edge that consumed that bit.
// ============================================================================
module tb_serial_frame_sync_ctrl;

    logic       CLK;
    logic       RESET;
    logic       S_IN;
    logic       S_VALID;
    logic [7:0] P_OUT;
    logic       P_VALID;
    logic       P_COMMA;
    logic       LOCKED;
    logic       SYNC_ERR;

    int         n_pass;
    int         n_total;
    int         pv_cnt;
    int         se_cnt;
    logic       last_pv;
    logic [7:0] last_out;
    logic       last_comma;

    serial_frame_sync_ctrl dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .S_IN     (S_IN),
        .S_VALID  (S_VALID),
        .P_OUT    (P_OUT),
        .P_VALID  (P_VALID),
        .P_COMMA  (P_COMMA),
        .LOCKED   (LOCKED),
        .SYNC_ERR (SYNC_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock with the given bit/strobe; records pulses seen afterwards.
    task automatic bit_step(input logic b, input logic v);
        S_IN    = b;
        S_VALID = v;
        @(negedge CLK);
        last_pv = P_VALID;
        if (P_VALID) begin
            pv_cnt++;
            last_out   = P_OUT;
            last_comma = P_COMMA;
        end
        if (SYNC_ERR)
            se_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] c);
        for (int i = 7; i >= 0; i--)
            bit_step(c[i], 1'b1);
    endtask

    task automatic clear_counts();
        pv_cnt     = 0;
        se_cnt     = 0;
        last_out   = 8'h00;
        last_comma = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        bit_step(1'b1, 1'b1);
        bit_step(1'b0, 1'b1);
        RESET = 1'b1;
        clear_counts();
    endtask

    task automatic lock_up();
        send_byte(8'hB4);
        send_byte(8'hB4);
        send_byte(8'hB4);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (P_OUT !== 8'h00) $display("FAIL rst_p_out: got %h expected 00", P_OUT); else n_pass++;
        n_total++; if (P_VALID !== 1'b0) $display("FAIL rst_p_valid: got %b expected 0", P_VALID); else n_pass++;
        n_total++; if (P_COMMA !== 1'b0) $display("FAIL rst_p_comma: got %b expected 0", P_COMMA); else n_pass++;
        n_total++; if (LOCKED !== 1'b0) $display("FAIL rst_locked: got %b expected 0", LOCKED); else n_pass++;
        n_total++; if (SYNC_ERR !== 1'b0) $display("FAIL rst_sync_err: got %b expected 0", SYNC_ERR); else n_pass++;
    endtask

    task automatic test_acquire();
        do_reset();
        bit_step(1'b1, 1'b1);
        bit_step(1'b0, 1'b1);
        bit_step(1'b1, 1'b1);
        send_byte(8'hB4);
        send_byte(8'hB4);
        n_total++; if (LOCKED !== 1'b0) $display("FAIL acq_early_lock: got %b expected 0", LOCKED); else n_pass++;
        send_byte(8'hB4);
        n_total++; if (LOCKED !== 1'b1) $display("FAIL acq_locked: got %b expected 1", LOCKED); else n_pass++;
        n_total++; if (pv_cnt !== 0) $display("FAIL acq_comma_not_emitted: got %0d pulses expected 0", pv_cnt); else n_pass++;
        send_byte(8'h5A);
        n_total++; if (last_pv !== 1'b1) $display("FAIL acq_latency: got P_VALID=%b after LSB expected 1", last_pv); else n_pass++;
        n_total++; if (pv_cnt !== 1) $display("FAIL acq_pulse_count: got %0d expected 1", pv_cnt); else n_pass++;
        n_total++; if (last_out !== 8'h5A) $display("FAIL acq_p_out: got %h expected 5a", last_out); else n_pass++;
        n_total++; if (last_comma !== 1'b0) $display("FAIL acq_p_comma: got %b expected 0", last_comma); else n_pass++;
    endtask

    task automatic test_verify_fail();
        do_reset();
        send_byte(8'hB4);
        send_byte(8'hB4);
        send_byte(8'h00);
        n_total++; if (LOCKED !== 1'b0) $display("FAIL vf_no_lock: got %b expected 0", LOCKED); else n_pass++;
        send_byte(8'hB4);
        send_byte(8'hB4);
        n_total++; if (LOCKED !== 1'b0) $display("FAIL vf_relock_early: got %b expected 0", LOCKED); else n_pass++;
        send_byte(8'hB4);
        n_total++; if (LOCKED !== 1'b1) $display("FAIL vf_relock: got %b expected 1", LOCKED); else n_pass++;
        n_total++; if (pv_cnt !== 0) $display("FAIL vf_no_pulses: got %0d expected 0", pv_cnt); else n_pass++;
    endtask

    task automatic test_loss();
        // Continues from the locked state left by test_verify_fail.
        clear_counts();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        n_total++; if (pv_cnt !== 3) $display("FAIL loss_emitted: got %0d expected 3", pv_cnt); else n_pass++;
        n_total++; if (last_out !== 8'h33) $display("FAIL loss_last_out: got %h expected 33", last_out); else n_pass++;
        send_byte(8'h44);
        n_total++; if (pv_cnt !== 3) $display("FAIL loss_dropped_char: got %0d pulses expected 3", pv_cnt); else n_pass++;
        n_total++; if (SYNC_ERR !== 1'b1) $display("FAIL loss_sync_err: got %b expected 1", SYNC_ERR); else n_pass++;
        n_total++; if (LOCKED !== 1'b0) $display("FAIL loss_unlocked: got %b expected 0", LOCKED); else n_pass++;
        bit_step(1'b0, 1'b0);
        n_total++; if (SYNC_ERR !== 1'b0) $display("FAIL loss_sync_err_pulse: got %b expected 0", SYNC_ERR); else n_pass++;
        n_total++; if (se_cnt !== 1) $display("FAIL loss_sync_err_count: got %0d expected 1", se_cnt); else n_pass++;

        // A comma after three non-commas restarts the gap budget.
        do_reset();
        lock_up();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'hB4);
        n_total++; if (last_out !== 8'hB4) $display("FAIL gap_comma_out: got %h expected b4", last_out); else n_pass++;
        n_total++; if (last_comma !== 1'b1) $display("FAIL gap_comma_flag: got %b expected 1", last_comma); else n_pass++;
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        n_total++; if (LOCKED !== 1'b1) $display("FAIL gap_lock_kept: got %b expected 1", LOCKED); else n_pass++;
        n_total++; if (pv_cnt !== 7) $display("FAIL gap_pulse_count: got %0d expected 7", pv_cnt); else n_pass++;
        n_total++; if (se_cnt !== 0) $display("FAIL gap_no_sync_err: got %0d expected 0", se_cnt); else n_pass++;
    endtask

    task automatic test_strobe_gaps();
        logic [7:0] ch;
        logic [7:0] hold_exp;
        int         hold_err;
        // Continues locked from test_loss with gap=3; a comma clears the budget.
        send_byte(8'hB4);
        clear_counts();
        ch       = 8'hA5;
        hold_err = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_step(ch[i], 1'b1);
            hold_exp = (i == 0) ? 8'hA5 : 8'hB4;
            if (P_OUT !== hold_exp) hold_err++;
            for (int k = 0; k < 2; k++) begin
                bit_step(~ch[i], 1'b0);
                if (P_VALID !== 1'b0 || P_OUT !== hold_exp || LOCKED !== 1'b1) hold_err++;
            end
        end
        n_total++; if (hold_err !== 0) $display("FAIL strobe_hold: got %0d bad cycles expected 0", hold_err); else n_pass++;
        n_total++; if (pv_cnt !== 1) $display("FAIL strobe_pulse_count: got %0d expected 1", pv_cnt); else n_pass++;
        n_total++; if (last_out !== 8'hA5) $display("FAIL strobe_p_out: got %h expected a5", last_out); else n_pass++;
    endtask

    task automatic test_reset_mid_char();
        // Locked from test_strobe_gaps; abort a character halfway.
        n_total++; if (LOCKED !== 1'b1) $display("FAIL mid_pre_locked: got %b expected 1", LOCKED); else n_pass++;
        bit_step(1'b1, 1'b1);
        bit_step(1'b1, 1'b1);
        bit_step(1'b1, 1'b1);
        bit_step(1'b1, 1'b1);
        do_reset();
        n_total++; if (LOCKED !== 1'b0) $display("FAIL mid_locked: got %b expected 0", LOCKED); else n_pass++;
        n_total++; if (P_OUT !== 8'h00) $display("FAIL mid_p_out: got %h expected 00", P_OUT); else n_pass++;
        n_total++; if (P_COMMA !== 1'b0) $display("FAIL mid_p_comma: got %b expected 0", P_COMMA); else n_pass++;
        send_byte(8'hB4);
        n_total++; if (LOCKED !== 1'b0) $display("FAIL mid_single_comma: got %b expected 0", LOCKED); else n_pass++;
        n_total++; if (pv_cnt !== 0) $display("FAIL mid_no_pulse: got %0d expected 0", pv_cnt); else n_pass++;
        send_byte(8'hB4);
        send_byte(8'hB4);
        n_total++; if (LOCKED !== 1'b1) $display("FAIL mid_relock: got %b expected 1", LOCKED); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        RESET   = 1'b0;
        S_IN    = 1'b0;
        S_VALID = 1'b0;
        clear_counts();
        last_pv = 1'b0;
        @(negedge CLK);

        test_reset();
        test_acquire();
        test_verify_fail();
        test_loss();
        test_strobe_gaps();
        test_reset_mid_char();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
